// File: rtl/ub_input_feeder.sv
// Streams a run of unified-buffer input vectors into the systolic array's
// activation edge, applying a triangular per-lane skew.
module ub_input_feeder #(
  parameter int SA_DIM = 16,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [LEN_W-1:0]         num_rows,
  output logic                     busy,
  output logic                     done,
  output logic                     ub_rd_input_en,
  output logic [ADDR_W-1:0]        ub_rd_input_addr_out,
  input  logic [SA_DIM-1:0][7:0]   ub_rd_input_data_in,
  output logic [SA_DIM-1:0][7:0]   sa_data_out,
  output logic [SA_DIM-1:0]        sa_valid_out
);

  localparam int DRN_W = $clog2(SA_DIM + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                   state_q;
  logic [ADDR_W-1:0]        base_q;
  logic [LEN_W-1:0]         num_q;
  logic [LEN_W-1:0]         rd_cnt_q;
  logic [DRN_W-1:0]         drain_cnt_q;
  logic [SA_DIM-1:0][7:0]   cap_data_q;
  logic                     cap_vld_q;

  logic [ADDR_W-1:0]        rd_addr_s;
  logic                     last_rd_s;
  logic                     last_drain_s;

  // The adder is deliberately ADDR_W wide so a run crossing the top of the buffer wraps to 0.
  assign rd_addr_s    = base_q + ADDR_W'(rd_cnt_q);
  assign last_rd_s    = (rd_cnt_q == (num_q - LEN_W'(1)));
  assign last_drain_s = (drain_cnt_q == DRN_W'(SA_DIM - 1));

  assign busy                 = (state_q != ST_IDLE);
  assign done                 = (state_q == ST_DONE);
  assign ub_rd_input_en       = (state_q == ST_READ);
  assign ub_rd_input_addr_out = (state_q == ST_READ) ? rd_addr_s : {ADDR_W{1'b0}};

  // Sequencer: IDLE -> READ (N cycles) -> DRAIN (SA_DIM cycles) -> DONE -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= {ADDR_W{1'b0}};
      num_q       <= {LEN_W{1'b0}};
      rd_cnt_q    <= {LEN_W{1'b0}};
      drain_cnt_q <= {DRN_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (num_rows != {LEN_W{1'b0}}) begin
              base_q   <= base_addr;
              num_q    <= num_rows;
              rd_cnt_q <= {LEN_W{1'b0}};
              state_q  <= ST_READ;
            end else begin
              state_q  <= ST_DONE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          rd_cnt_q <= rd_cnt_q + LEN_W'(1);
          if (last_rd_s) begin
            drain_cnt_q <= {DRN_W{1'b0}};
            state_q     <= ST_DRAIN;
          end else begin
            state_q     <= ST_READ;
          end
        end
        ST_DRAIN: begin
          drain_cnt_q <= drain_cnt_q + DRN_W'(1);
          if (last_drain_s) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture stage: a cycle without a read injects a zero, invalid bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_data_q <= '0;
      cap_vld_q  <= 1'b0;
    end else if (ub_rd_input_en) begin
      cap_data_q <= ub_rd_input_data_in;
      cap_vld_q  <= 1'b1;
    end else begin
      cap_data_q <= '0;
      cap_vld_q  <= 1'b0;
    end
  end

  for (genvar k = 0; k < SA_DIM; k++) begin : g_lane
    if (k == 0) begin : g_direct
      assign sa_data_out[k]  = cap_data_q[k];
      assign sa_valid_out[k] = cap_vld_q;
    end else begin : g_skew
      logic [7:0] sh_data_q [k];
      logic       sh_vld_q  [k];

      // Lane k trails lane 0 by k cycles through its own k-deep shift register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            sh_data_q[i] <= 8'h00;
            sh_vld_q[i]  <= 1'b0;
          end
        end else begin
          sh_data_q[0] <= cap_data_q[k];
          sh_vld_q[0]  <= cap_vld_q;
          for (int i = 1; i < k; i++) begin
            sh_data_q[i] <= sh_data_q[i-1];
            sh_vld_q[i]  <= sh_vld_q[i-1];
          end
        end
      end

      assign sa_data_out[k]  = sh_data_q[k-1];
      assign sa_valid_out[k] = sh_vld_q[k-1];
    end
  end

endmodule

// File: tb/tb_ub_input_feeder.sv
// Directed and randomized bench for ub_input_feeder against a cycle-table
// reference model built from the run timing rules.
module tb_ub_input_feeder;

  localparam int SA_DIM = 16;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 10;
  localparam int NCYC   = 2048;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [ADDR_W-1:0]      base_addr;
  logic [LEN_W-1:0]       num_rows;
  logic                   busy;
  logic                   done;
  logic                   ub_rd_input_en;
  logic [ADDR_W-1:0]      ub_rd_input_addr_out;
  logic [SA_DIM-1:0][7:0] ub_rd_input_data_in;
  logic [SA_DIM-1:0][7:0] sa_data_out;
  logic [SA_DIM-1:0]      sa_valid_out;

  logic [SA_DIM-1:0][7:0] mem [1024];

  logic                   exp_en   [NCYC];
  logic [ADDR_W-1:0]      exp_addr [NCYC];
  logic                   exp_busy [NCYC];
  logic                   exp_done [NCYC];
  logic [SA_DIM-1:0]      exp_vld  [NCYC];
  logic [SA_DIM-1:0][7:0] exp_dat  [NCYC];

  logic [7:0]             obs0     [NCYC];
  logic [7:0]             obs15    [NCYC];
  logic                   obs_done [NCYC];
  logic                   obs_busy [NCYC];
  int                     vld_cnt  [SA_DIM];

  int cyc;
  int idle_from;
  int n_checks;
  int n_fail;
  int s;

  always #5 clk = ~clk;

  assign ub_rd_input_data_in = mem[ub_rd_input_addr_out];

  ub_input_feeder #(.SA_DIM(SA_DIM), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .base_addr            (base_addr),
    .num_rows             (num_rows),
    .busy                 (busy),
    .done                 (done),
    .ub_rd_input_en       (ub_rd_input_en),
    .ub_rd_input_addr_out (ub_rd_input_addr_out),
    .ub_rd_input_data_in  (ub_rd_input_data_in),
    .sa_data_out          (sa_data_out),
    .sa_valid_out         (sa_valid_out)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model_from(input int c);
    for (int i = c; i < NCYC; i++) begin
      exp_en[i]   = 1'b0;
      exp_addr[i] = '0;
      exp_busy[i] = 1'b0;
      exp_done[i] = 1'b0;
      exp_vld[i]  = '0;
      exp_dat[i]  = '0;
    end
  endtask

  // A start seen in cycle st is accepted at the edge ending that cycle.
  task automatic schedule(input int st, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
    int nn;
    int a;
    nn = int'(n);
    if (nn == 0) begin
      exp_busy[st+1] = 1'b1;
      exp_done[st+1] = 1'b1;
      idle_from = st + 2;
    end else begin
      for (int i = 0; i < nn; i++) begin
        a = (int'(b) + i) % 1024;
        exp_en[st+1+i]   = 1'b1;
        exp_addr[st+1+i] = ADDR_W'(a);
        for (int k = 0; k < SA_DIM; k++) begin
          exp_vld[st+2+i+k][k] = 1'b1;
          exp_dat[st+2+i+k][k] = mem[a][k];
        end
      end
      for (int c = st + 1; c <= st + nn + SA_DIM + 1; c++) exp_busy[c] = 1'b1;
      exp_done[st+nn+SA_DIM+1] = 1'b1;
      idle_from = st + nn + SA_DIM + 2;
    end
  endtask

  task automatic step(input logic st, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n, input logic r);
    rst       = r;
    start     = st;
    base_addr = b;
    num_rows  = n;
    if (r) begin
      clear_model_from(cyc);
      idle_from = cyc + 1;
    end
    @(negedge clk);
    check("rd_en",   {127'd0, ub_rd_input_en}, {127'd0, exp_en[cyc]});
    check("rd_addr", {118'd0, ub_rd_input_addr_out}, {118'd0, exp_addr[cyc]});
    check("busy",    {127'd0, busy}, {127'd0, exp_busy[cyc]});
    check("done",    {127'd0, done}, {127'd0, exp_done[cyc]});
    check("valid",   {112'd0, sa_valid_out}, {112'd0, exp_vld[cyc]});
    check("data",    sa_data_out, exp_dat[cyc]);
    obs0[cyc]     = sa_data_out[0];
    obs15[cyc]    = sa_data_out[15];
    obs_done[cyc] = done;
    obs_busy[cyc] = busy;
    for (int k = 0; k < SA_DIM; k++) vld_cnt[k] += int'(sa_valid_out[k]);
    if (st && !r && cyc >= idle_from) schedule(cyc, b, n);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    idle_from = 0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    clear_model_from(0);
    for (int a = 0; a < 1024; a++)
      for (int k = 0; k < SA_DIM; k++) mem[a][k] = {a[3:0], k[3:0]};

    // Reset state.
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 10'h123, 10'd4, 1'b1);
    idle(2);

    // Patterned N=4 run from 0x010.
    s = cyc;
    step(1'b1, 10'h010, 10'd4, 1'b0);
    idle(24);
    for (int i = 0; i < 4; i++) begin
      check("tp1_lane0",  {120'd0, obs0[s+2+i]},  {120'd0, 8'(i * 16)});
      check("tp1_lane15", {120'd0, obs15[s+17+i]}, {120'd0, 8'(i * 16 + 15)});
    end
    check("tp1_done_c20", {127'd0, obs_done[s+20]}, 128'd0);
    check("tp1_done_c21", {127'd0, obs_done[s+21]}, 128'd1);
    check("tp1_busy_c22", {127'd0, obs_busy[s+22]}, 128'd0);

    // Zero-length run.
    step(1'b1, 10'h055, 10'd0, 1'b0);
    idle(3);

    // Address wrap with random buffer contents.
    for (int a = 0; a < 1024; a++)
      for (int k = 0; k < SA_DIM; k++) mem[a][k] = 8'($urandom);
    for (int k = 0; k < SA_DIM; k++) vld_cnt[k] = 0;
    step(1'b1, 10'h3FE, 10'd4, 1'b0);
    idle(24);
    for (int k = 0; k < SA_DIM; k++) check("wrap_beats", 128'(vld_cnt[k]), 128'd4);

    // Starts in cycles 3 and 21 ignored, cycle 22 accepted.
    s = cyc;
    step(1'b1, 10'h100, 10'd4, 1'b0);
    idle(2);
    step(1'b1, 10'h200, 10'd7, 1'b0);
    idle(17);
    step(1'b1, 10'h300, 10'd9, 1'b0);
    step(1'b1, 10'h050, 10'd2, 1'b0);
    idle(22);

    // Reset in cycle 6 of an N=8 run.
    s = cyc;
    step(1'b1, 10'($urandom), 10'd8, 1'b0);
    idle(5);
    step(1'b0, '0, '0, 1'b1);
    idle(30);

    // Back-to-back N=1 runs.
    step(1'b1, 10'($urandom), 10'd1, 1'b0);
    idle(18);
    step(1'b1, 10'($urandom), 10'd1, 1'b0);
    idle(22);

    // Random starts; the model decides which ones are accepted.
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 7) == 0), 10'($urandom), 10'($urandom_range(0, 20)), 1'b0);
    idle(45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
